// File: rtl/bus_arbiter_if.sv
// Bus arbitration handshake bundle: per-master request/done in, one-hot grant and status out.
// The master modport faces the requesting blocks; the slave modport faces the arbiter.
interface bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               timeout;

    modport master (
        output req, done,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_id, busy, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared Addr/Data bus with one idle turnaround cycle between owners.
// Optional forced release of a stuck owner is compiled in with `define BUS_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic       clk,
    input logic       rst_n,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWNED,
        S_TURN
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               to_q, to_d;

    logic               found;
    logic [ID_W-1:0]    win_id;
    logic               normal_rel;
    logic               expired;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign expired = (state_q == S_OWNED) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    // First pending request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned idx;
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[ID_W'(idx)]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end
    end

    assign normal_rel = bus.done[gid_q] || !bus.req[gid_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        to_d    = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = NUM_REQ'(1) << win_id;
                    gid_d   = win_id;
                    state_d = S_OWNED;
`ifdef BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_OWNED: begin
                if (normal_rel || expired) begin
                    grant_d = '0;
                    ptr_d   = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
                    state_d = S_TURN;
                    to_d    = !normal_rel;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            to_q    <= to_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign bus.grant    = grant_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.timeout  = to_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against an owner/gap model.
// Honours `define BUS_TIMEOUT_EN for the forced-release scenario.
module tb_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 8;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bus_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

    bus_arbiter #(
        .NUM_REQ(N),
        .ID_W(IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus (-1 = nobody), idle cycles still owed, rotation start, ownership age.
    int m_owner, m_last, m_ptr, m_gap, m_age;
    bit m_to;

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_gap = 0; m_age = 0; m_to = 1'b0;
    endtask

    task automatic model_edge();
        m_to = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner >= 0) begin
            bit rel, forced;
            m_age++;
            rel    = bus.done[m_owner] || !bus.req[m_owner];
            forced = TO_EN && !rel && (m_age == TO);
            if (rel || forced) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1;
                m_to    = forced;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && bus.req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_age  = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("grant",    32'(bus.grant), eg);
        check("grant_id", 32'(bus.grant_id), 32'(m_last));
        check("busy",     32'(bus.busy), 32'((m_owner >= 0) || (m_gap > 0)));
        check("timeout",  32'(bus.timeout), 32'(m_to));
        check("onehot0",  32'($onehot0(bus.grant)), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_grant(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            tick();
            if (bus.grant != '0) got = 1'b1;
        end
        check({tag, "_grant_bound"}, 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        model_reset();

        // 1: reset with all requests pending, then first grant one clock after release
        bus.req = 4'b1111;
        #2;
        compare_all();
        check("rst_grant", 32'(bus.grant), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_first_grant", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        repeat (3) tick();

        // 2: single requester with done pulse
        bus.req = 4'b0100;
        tick();
        check("single_grant", 32'(bus.grant), 32'b0100);
        check("single_id", 32'(bus.grant_id), 32'd2);
        bus.done = 4'b0100;
        tick();
        bus.done = '0;
        bus.req  = '0;
        check("single_turn_busy", 32'(bus.busy), 32'd1);
        check("single_turn_grant", 32'(bus.grant), 32'd0);
        tick();
        check("single_idle_busy", 32'(bus.busy), 32'd0);

        // 3: round robin with all requests held
        do_reset();
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr");
            check("rr_order", 32'(bus.grant_id), 32'(g % N));
            tick();
            bus.done = bus.grant;
            tick();
            bus.done = '0;
        end
        bus.req = '0;
        repeat (3) tick();

        // 4: owner's done collides with a new low-index request
        do_reset();
        bus.req = 4'b0110;
        tick();
        check("coll_owner", 32'(bus.grant), 32'b0010);
        bus.done = 4'b0010;
        bus.req  = 4'b0101;
        tick();
        bus.done = '0;
        wait_grant("coll1");
        check("coll_next", 32'(bus.grant), 32'b0100);
        bus.done = 4'b0100;
        bus.req  = 4'b0001;
        tick();
        bus.done = '0;
        wait_grant("coll2");
        check("coll_after", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        repeat (3) tick();

        // 5: asynchronous reset while requester 3 owns the bus
        bus.req = 4'b1000;
        wait_grant("mid");
        check("mid_owner", 32'(bus.grant), 32'b1000);
        rst_n = 1'b0;
        model_reset();
        #2;
        check("mid_async_grant", 32'(bus.grant), 32'd0);
        check("mid_async_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_regrant_id", 32'(bus.grant_id), 32'd3);
        bus.req = '0;
        repeat (3) tick();

        // 6: owner never signals done
        do_reset();
        bus.req = 4'b0010;
        tick();
        check("to_grant", 32'(bus.grant), 32'b0010);
        if (TO_EN) begin
            int held;
            held = 1;
            while (bus.grant != '0 && held < 40) begin
                tick();
                if (bus.grant != '0) held++;
            end
            check("to_held_cycles", 32'(held), 32'(TO));
            check("to_pulse", 32'(bus.timeout), 32'd1);
            check("to_id", 32'(bus.grant_id), 32'd1);
            tick();
            check("to_pulse_end", 32'(bus.timeout), 32'd0);
        end else begin
            repeat (100) tick();
            check("to_still_held", 32'(bus.grant), 32'b0010);
            check("to_never", 32'(bus.timeout), 32'd0);
        end
        bus.req = '0;
        repeat (4) tick();

        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            bus.done = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            tick();
        end
        bus.req  = '0;
        bus.done = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
